// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared types, sizes and priority encoder for irq_controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int c_ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ENTER = 2'd2
    } irq_state_e;

    typedef struct packed {
        logic              valid;
        logic [c_ID_W-1:0] idx;
    } irq_sel_t;

    // Highest set bit wins; valid=0 when the vector is empty.
    function automatic irq_sel_t highest_bit(input logic [NUM_IRQ-1:0] req);
        irq_sel_t sel;
        sel = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                sel.valid = 1'b1;
                sel.idx   = c_ID_W'(i);
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Brief    : Two-flop synchronizer with rising-edge detect for one request line.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Vectored, nesting interrupt controller with per-level EPC store.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         ir_in,
    input  logic               ie,
    input  logic               mask_we,
    input  logic [3:0]         mask_wdata,
    input  logic               inst_end,
    input  logic [ADDR_W-1:0]  pc_next,
    input  logic               eret,
    output logic               int_req,
    output logic               int_take,
    output logic [ADDR_W-1:0]  int_vector,
    output logic               ret_take,
    output logic [ADDR_W-1:0]  epc_out,
    output logic [3:0]         pending,
    output logic [3:0]         in_service
);

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_clr;
    irq_sel_t           w_hi_srv;
    irq_sel_t           w_win;
    logic               w_ret;
    logic [ADDR_W-1:0]  w_vector;

    irq_state_e         r_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] r_mask;
    logic [c_ID_W-1:0]  r_cur_id;
    logic [ADDR_W-1:0]  r_epc [NUM_IRQ];
    logic               r_int_req;
    logic               r_int_take;
    logic [ADDR_W-1:0]  r_int_vector;
    logic               r_ret_take;
    logic [ADDR_W-1:0]  r_epc_out;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (ir_in[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // Only lines above the deepest active level may preempt.
    always_comb begin
        w_hi_srv = highest_bit(r_in_service);
        w_elig   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_elig[i] = !w_hi_srv.valid || (c_ID_W'(i) > w_hi_srv.idx);
        end
        w_cand   = r_pending & ~r_mask & w_elig;
        w_win    = highest_bit(w_cand);
        w_ret    = eret && w_hi_srv.valid && (r_state != ST_ENTER);
        w_vector = VEC_BASE + ADDR_W'(w_win.idx) * VEC_STRIDE;
        w_clr    = '0;
        if (r_state == ST_ENTER) begin
            w_clr[r_cur_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= '0;
            r_cur_id     <= '0;
            r_int_req    <= 1'b0;
            r_int_take   <= 1'b0;
            r_int_vector <= '0;
            r_ret_take   <= 1'b0;
            r_epc_out    <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                r_epc[i] <= '0;
            end
        end else begin
            // A fresh edge wins over the clear issued by ENTER.
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            r_int_take   <= 1'b0;
            r_int_vector <= '0;
            r_ret_take   <= w_ret;
            r_epc_out    <= w_ret ? r_epc[w_hi_srv.idx] : '0;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_ret) begin
                r_in_service[w_hi_srv.idx] <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ie && w_win.valid) begin
                        r_state   <= ST_ARMED;
                        r_int_req <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!ie || !w_win.valid) begin
                        r_state   <= ST_IDLE;
                        r_int_req <= 1'b0;
                    end else if (inst_end && !eret) begin
                        r_state             <= ST_ENTER;
                        r_int_req           <= 1'b0;
                        r_cur_id            <= w_win.idx;
                        r_epc[w_win.idx]    <= pc_next;
                        r_int_take          <= 1'b1;
                        r_int_vector        <= w_vector;
                    end
                end
                ST_ENTER: begin
                    r_state                <= ST_IDLE;
                    r_in_service[r_cur_id] <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign int_take   = r_int_take;
    assign int_vector = r_int_vector;
    assign ret_take   = r_ret_take;
    assign epc_out    = r_epc_out;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed vector bench for irq_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ir_in;
    logic        ie;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        inst_end;
    logic [31:0] pc_next;
    logic        eret;
    logic        int_req;
    logic        int_take;
    logic [31:0] int_vector;
    logic        ret_take;
    logic [31:0] epc_out;
    logic [3:0]  pending;
    logic [3:0]  in_service;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  ir;
        logic        ie;
        logic        mwe;
        logic [3:0]  mwd;
        logic        iend;
        logic [31:0] pc;
        logic        eret;
        logic        req;
        logic        take;
        logic [31:0] vec;
        logic        ret;
        logic [31:0] epc;
        logic [3:0]  pend;
        logic [3:0]  isv;
    } vec_t;

    vec_t tbl[$];

    irq_controller dut (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (ir_in),
        .ie         (ie),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .inst_end   (inst_end),
        .pc_next    (pc_next),
        .eret       (eret),
        .int_req    (int_req),
        .int_take   (int_take),
        .int_vector (int_vector),
        .ret_take   (ret_take),
        .epc_out    (epc_out),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] ir, input logic ien, input logic mwe,
                                input logic [3:0] mwd, input logic iend, input logic [31:0] pc,
                                input logic er, input logic req, input logic take,
                                input logic [31:0] vec, input logic ret, input logic [31:0] epc,
                                input logic [3:0] pend, input logic [3:0] isv);
        vec_t v;
        v.ir = ir;   v.ie = ien;   v.mwe = mwe;   v.mwd = mwd;
        v.iend = iend; v.pc = pc;  v.eret = er;
        v.req = req; v.take = take; v.vec = vec;  v.ret = ret;
        v.epc = epc; v.pend = pend; v.isv = isv;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, got, exp);
        end
    endtask

    task automatic chk_zero(input int step);
        chk("int_req",    step, 32'(int_req),    32'h0);
        chk("int_take",   step, 32'(int_take),   32'h0);
        chk("int_vector", step, int_vector,      32'h0);
        chk("ret_take",   step, 32'(ret_take),   32'h0);
        chk("epc_out",    step, epc_out,         32'h0);
        chk("pending",    step, 32'(pending),    32'h0);
        chk("in_service", step, 32'(in_service), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ir, input logic ien, input logic iend,
                         input logic [31:0] pc, input logic er);
        ir_in = ir; ie = ien; inst_end = iend; pc_next = pc; eret = er;
        mask_we = 1'b0; mask_wdata = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        //        ir     ie mwe mwd  iend pc          eret req take vec        ret epc         pend     isv
        // line 1 entry and return
        tbl.push_back(mk(4'b0010,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0010,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0010,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h40,     0,  0,1,32'h110,   0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h40,    4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        // simultaneous lines 0 and 2
        tbl.push_back(mk(4'b0101,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0101,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0101,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0101,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0101,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h80,     0,  0,1,32'h120,   0,32'h0,     4'b0101,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b0100));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b0100));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h80,    4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h90,     0,  0,1,32'h100,   0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0001));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h90,    4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        // masked line 2, then unmask
        tbl.push_back(mk(4'b0000,1,1,4'h4,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0100,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0100,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0100,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0100,4'b0000));
        tbl.push_back(mk(4'b0000,1,1,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0100,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0100,4'b0000));
        // take line 2, arm line 3, then inst_end with eret
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'hA0,     0,  0,1,32'h120,   0,32'h0,     4'b0100,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0100));
        tbl.push_back(mk(4'b1000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0100));
        tbl.push_back(mk(4'b1000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0100));
        tbl.push_back(mk(4'b1000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b1000,4'b0100));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b1000,4'b0100));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'hB0,     1,  1,0,32'h0,     1,32'hA0,    4'b1000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'hC0,     0,  0,1,32'h130,   0,32'h0,     4'b1000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b1000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'hC0,    4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        // nesting: line 1 in service, lines 3 and 0 arrive
        tbl.push_back(mk(4'b0010,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0010,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h200,    0,  0,1,32'h110,   0,32'h0,     4'b0010,4'b0000));
        tbl.push_back(mk(4'b1001,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0010));
        tbl.push_back(mk(4'b1001,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b1001,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b1001,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h300,    0,  0,1,32'h130,   0,32'h0,     4'b1001,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b1010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b1010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h300,   4'b0001,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b0010));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h200,   4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0001,4'b0000));
        // ie drop disarms, re-enable re-arms
        tbl.push_back(mk(4'b0000,0,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,0,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  1,0,32'h0,     0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,1,32'h400,    0,  0,1,32'h100,   0,32'h0,     4'b0001,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0001));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      1,  0,0,32'h0,     1,32'h400,   4'b0000,4'b0000));
        tbl.push_back(mk(4'b0000,1,0,4'h0,0,32'h0,      0,  0,0,32'h0,     0,32'h0,     4'b0000,4'b0000));

        tick();
        chk_zero(-2);
        tick();
        chk_zero(-1);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            ir_in = tbl[i].ir;   ie = tbl[i].ie;
            mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
            inst_end = tbl[i].iend; pc_next = tbl[i].pc; eret = tbl[i].eret;
            tick();
            chk("int_req",    i, 32'(int_req),    32'(tbl[i].req));
            chk("int_take",   i, 32'(int_take),   32'(tbl[i].take));
            chk("ret_take",   i, 32'(ret_take),   32'(tbl[i].ret));
            chk("pending",    i, 32'(pending),    32'(tbl[i].pend));
            chk("in_service", i, 32'(in_service), 32'(tbl[i].isv));
            if (tbl[i].take) chk("int_vector", i, int_vector, tbl[i].vec);
            if (tbl[i].ret)  chk("epc_out",    i, epc_out,    tbl[i].epc);
        end

        // Line 1 re-edges in the very cycle ENTER clears its pending bit.
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0); tick(); tick(); tick();
        chk("pending", 100, 32'(pending), 32'h2);
        drive(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        chk("int_req", 101, 32'(int_req), 32'h1);
        tick();
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        drive(4'b0010, 1'b1, 1'b1, 32'h500, 1'b0); tick();
        chk("int_take",   102, 32'(int_take), 32'h1);
        chk("int_vector", 102, int_vector,    32'h110);
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        chk("pending",    103, 32'(pending),    32'h2);
        chk("in_service", 103, 32'(in_service), 32'h2);
        chk("int_req",    103, 32'(int_req),    32'h0);
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b1); tick();
        chk("ret_take",   104, 32'(ret_take),   32'h1);
        chk("epc_out",    104, epc_out,         32'h500);
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        chk("int_req",    105, 32'(int_req),    32'h1);

        // Reset arriving while int_take is high.
        drive(4'b0010, 1'b1, 1'b1, 32'h600, 1'b0); tick();
        chk("int_take",   106, 32'(int_take), 32'h1);
        #1 rst = 1'b1;
        drive(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk_zero(107);
        tick();
        chk_zero(108);
        rst = 1'b0;
        tick();
        chk_zero(109);
        tick();
        chk_zero(110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
